// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage with a single-outstanding imem port.
//
// Fetches one instruction at a time from pc_o and loads it into the IF/ID
// register. A one-entry buffer holds a response that arrives during a stall.
// Redirects flush IF/ID and can discard one stale in-flight response.
//
// Ports
//   clk_i           single clock, rising edge
//   rst_ni          synchronous active-low reset
//   next_pc_i       redirect target, bits [1:0] ignored
//   redirect_i      flush fetch and load next_pc_i
//   stall_i         freeze IF/ID and pc
//   imem_ready_i    memory accepts the request this cycle
//   imem_rvalid_i   memory returns data this cycle
//   imem_rdata_i    returned instruction word
//   imem_req_o      fetch request valid
//   imem_addr_o     fetch address (= pc_o)
//   pc_o            current fetch pc
//   if_id_pc_o      pc of the IF/ID instruction
//   if_id_instr_o   IF/ID instruction
//   if_id_valid_o   IF/ID holds a live instruction
//
// state  | meaning
// S_REQ  | request outstanding on the imem port
// S_WAIT | request accepted, awaiting response
// S_HOLD | response buffered while stalled
// S_DROP | discard one stale response after a redirect
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] next_pc_i,
  input  logic        redirect_i,
  input  logic        stall_i,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] pc_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] buf_q, buf_d;

  // Low address bits of the redirect target are deliberately dropped.
  logic unused_next_pc_lsb;
  assign unused_next_pc_lsb = ^next_pc_i[1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= S_REQ;
      pc_q          <= {RESET_PC[31:2], 2'b00};
      if_id_pc_q    <= 32'h0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      buf_q         <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      buf_q         <= buf_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    buf_d         = buf_q;

    if (redirect_i) begin
      pc_d          = {next_pc_i[31:2], 2'b00};
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
      buf_d         = 32'h0;
      // Only a still-pending response (WAIT or DROP without rvalid) must be
      // swallowed; otherwise start fetching the new target immediately.
      if ((state_q == S_WAIT || state_q == S_DROP) && !imem_rvalid_i) begin
        state_d = S_DROP;
      end else begin
        state_d = S_REQ;
      end
    end else if (stall_i) begin
      // IF/ID and pc frozen; the fetch handshake still advances.
      unique case (state_q)
        S_REQ:  if (imem_ready_i) state_d = S_WAIT;
        S_WAIT: if (imem_rvalid_i) begin
                  buf_d   = imem_rdata_i;
                  state_d = S_HOLD;
                end
        S_HOLD: state_d = S_HOLD;
        S_DROP: if (imem_rvalid_i) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end else begin
      // Bubble unless a load below overrides it.
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
      unique case (state_q)
        S_REQ:  if (imem_ready_i) state_d = S_WAIT;
        S_WAIT: if (imem_rvalid_i) begin
                  if_id_pc_d    = pc_q;
                  if_id_instr_d = imem_rdata_i;
                  if_id_valid_d = 1'b1;
                  pc_d          = pc_q + 32'd4;
                  state_d       = S_REQ;
                end
        S_HOLD: begin
                  if_id_pc_d    = pc_q;
                  if_id_instr_d = buf_q;
                  if_id_valid_d = 1'b1;
                  pc_d          = pc_q + 32'd4;
                  buf_d         = 32'h0;
                  state_d       = S_REQ;
                end
        S_DROP: if (imem_rvalid_i) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  assign imem_req_o    = rst_ni && (state_q == S_REQ);
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_instr_o = if_id_instr_q;
  assign if_id_valid_o = if_id_valid_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        redirect;
  logic        stall;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  int errors = 0;
  int checks = 0;

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .next_pc_i     (next_pc),
    .redirect_i    (redirect),
    .stall_i       (stall),
    .imem_ready_i  (imem_ready),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .pc_o          (pc),
    .if_id_pc_o    (if_id_pc),
    .if_id_instr_o (if_id_instr),
    .if_id_valid_o (if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ifid(input string tag, input logic [31:0] epc, input logic [31:0] ein,
                      input logic ev);
    chk({tag, ".if_id_pc"},    if_id_pc,    epc);
    chk({tag, ".if_id_instr"}, if_id_instr, ein);
    chk({tag, ".if_id_valid"}, {31'b0, if_id_valid}, {31'b0, ev});
  endtask

  // Zero-wait fetch: accept this cycle, respond next cycle.
  task automatic fetch(input logic [31:0] word);
    imem_ready = 1'b1;
    tick();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    tick();
    imem_rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; next_pc = '0; redirect = 1'b0; stall = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    #1;
    chk("rst.req_low_async_view", {31'b0, imem_req}, 32'd0);
    tick(); tick();
    chk("rst.pc", pc, 32'h0);
    ifid("rst", 32'h0, NOP, 1'b0);
    chk("rst.req", {31'b0, imem_req}, 32'd0);

    // Reset release and a zero-wait fetch
    rst_n = 1'b1;
    #1;
    chk("rel.req", {31'b0, imem_req}, 32'd1);
    chk("rel.addr", imem_addr, 32'h0);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    chk("wait.req", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    tick();
    imem_rvalid = 1'b0;
    ifid("zw", 32'h0, 32'h0050_0093, 1'b1);
    chk("zw.pc", pc, 32'h4);
    chk("zw.addr", imem_addr, 32'h4);

    // imem_ready low for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nr.req", {31'b0, imem_req}, 32'd1);
      chk("nr.addr", imem_addr, 32'h4);
    end
    chk("nr.bubble", {31'b0, if_id_valid}, 32'd0);
    fetch(32'h1111_1111);
    ifid("nr", 32'h4, 32'h1111_1111, 1'b1);
    chk("nr.pc", pc, 32'h8);
    tick();
    chk("nr.single_load", {31'b0, if_id_valid}, 32'd0);

    // Advance to pc=0x10
    fetch(32'h2222_2222);
    fetch(32'h4444_4444);
    ifid("adv", 32'hC, 32'h4444_4444, 1'b1);
    chk("adv.pc", pc, 32'h10);

    // Stall for 4 cycles spanning the response at pc=0x10
    stall = 1'b1; imem_ready = 1'b1;
    tick();                                    // S_REQ -> S_WAIT
    imem_ready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
    tick();                                    // S_WAIT -> S_HOLD
    imem_rvalid = 1'b0;
    ifid("stl1", 32'hC, 32'h4444_4444, 1'b1);
    chk("stl1.pc", pc, 32'h10);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;  // ignored in S_HOLD
    tick();
    imem_rvalid = 1'b0;
    tick();
    ifid("stl3", 32'hC, 32'h4444_4444, 1'b1);
    chk("stl3.req", {31'b0, imem_req}, 32'd0);
    stall = 1'b0;
    tick();
    ifid("unstl", 32'h10, 32'h3333_3333, 1'b1);
    chk("unstl.pc", pc, 32'h14);

    // Redirect during S_WAIT, stale response 2 cycles later
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    redirect = 1'b1; next_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    chk("rd.pc", pc, 32'h100);
    ifid("rd", 32'h10, NOP, 1'b0);
    chk("rd.req_drop", {31'b0, imem_req}, 32'd0);
    tick();
    chk("rd.req_drop2", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hBADB_AD00;
    tick();
    imem_rvalid = 1'b0;
    chk("rd.stale_valid", {31'b0, if_id_valid}, 32'd0);
    chk("rd.stale_instr", if_id_instr, NOP);
    chk("rd.req", {31'b0, imem_req}, 32'd1);
    chk("rd.addr", imem_addr, 32'h100);
    fetch(32'h5555_5555);
    ifid("rd.new", 32'h100, 32'h5555_5555, 1'b1);
    chk("rd.new_pc", pc, 32'h104);

    // Redirect + stall + rvalid together
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    redirect = 1'b1; stall = 1'b1; next_pc = 32'h0000_0200;
    imem_rvalid = 1'b1; imem_rdata = 32'h6666_6666;
    tick();
    redirect = 1'b0; stall = 1'b0; imem_rvalid = 1'b0;
    chk("rs.pc", pc, 32'h200);
    ifid("rs", 32'h100, NOP, 1'b0);
    chk("rs.req", {31'b0, imem_req}, 32'd1);
    chk("rs.addr", imem_addr, 32'h200);

    // Reset during S_WAIT
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mr.pc", pc, 32'h0);
    ifid("mr", 32'h0, NOP, 1'b0);
    chk("mr.req", {31'b0, imem_req}, 32'd0);
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'h7777_7777;
    tick();
    imem_rvalid = 1'b0;
    ifid("mr.post", 32'h0, NOP, 1'b0);
    chk("mr.post_pc", pc, 32'h0);
    chk("mr.post_req", {31'b0, imem_req}, 32'd1);
    chk("mr.post_addr", imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
